// File: rtl/multdiv_unit.sv
// multdiv_unit: iterative signed multiplier (radix-4 Booth) and restoring divider with tagged completion
module multdiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             ctrl_reset,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic [4:0]       ctrl_tagIn,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             data_busy,
  output logic [4:0]       data_tagOut
);
  localparam logic [1:0] IDLE = 2'd0, MULT = 2'd1, DIV = 2'd2, DONE = 2'd3;
  logic [1:0] state;
  logic [5:0] cnt;
  logic [2*WIDTH-1:0] acc, m, m2, pp;
  logic [WIDTH-1:0] q, a_mag, b_mag;
  logic [WIDTH:0] r_sh, d_ext;
  logic [4:0] tag;
  logic [2:0] sel;
  logic g, neg, dz, ovf, start, ge;
  always_comb begin
    data_busy = state == MULT || state == DIV;
    data_resultRDY = state == DONE;
    start = !data_busy && (ctrl_MULT ^ ctrl_DIV);
    a_mag = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
    b_mag = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;
    sel = {q[1:0], g};
    m2 = m << 1;
    pp = (sel == 3'b001 || sel == 3'b010) ? m :
         sel == 3'b011 ? m2 :
         sel == 3'b100 ? -m2 :
         (sel == 3'b101 || sel == 3'b110) ? -m : '0;
    r_sh = {acc[WIDTH-1:0], q[WIDTH-1]};
    d_ext = {1'b0, m[WIDTH-1:0]};
    ge = r_sh >= d_ext;
  end
  // acc/m/q are shared: Booth accumulator/multiplicand/multiplier, or remainder/divisor/quotient
  always_ff @(posedge clock) begin
    if (!ctrl_reset) begin
      state <= IDLE;
      cnt <= '0;
      acc <= '0;
      m <= '0;
      q <= '0;
      g <= 1'b0;
      neg <= 1'b0;
      dz <= 1'b0;
      ovf <= 1'b0;
      tag <= '0;
      data_result <= '0;
      data_exception <= 1'b0;
      data_tagOut <= '0;
    end else if (start) begin
      state <= ctrl_MULT ? MULT : DIV;
      cnt <= '0;
      acc <= '0;
      g <= 1'b0;
      tag <= ctrl_tagIn;
      m <= ctrl_MULT ? {{WIDTH{data_operandA[WIDTH-1]}}, data_operandA} : {{WIDTH{1'b0}}, b_mag};
      q <= ctrl_MULT ? data_operandB : a_mag;
      neg <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
      dz <= data_operandB == '0;
      ovf <= data_operandA == {1'b1, {(WIDTH-1){1'b0}}} && &data_operandB;
    end else if (state == MULT && cnt == 6'(WIDTH/2)) begin
      state <= DONE;
      data_result <= acc[WIDTH-1:0];
      data_exception <= !(&acc[2*WIDTH-1:WIDTH-1] || ~|acc[2*WIDTH-1:WIDTH-1]);
      data_tagOut <= tag;
    end else if (state == MULT) begin
      acc <= acc + pp;
      m <= m << 2;
      q <= q >> 2;
      g <= q[1];
      cnt <= cnt + 1'b1;
    end else if (state == DIV && cnt == 6'(WIDTH)) begin
      state <= DONE;
      data_result <= dz ? '0 : neg ? -q : q;
      data_exception <= dz || ovf;
      data_tagOut <= tag;
    end else if (state == DIV) begin
      acc <= {{(WIDTH-1){1'b0}}, ge ? r_sh - d_ext : r_sh};
      q <= {q[WIDTH-2:0], ge};
      cnt <= cnt + 1'b1;
    end else if (state == DONE) begin
      state <= IDLE;
    end
  end
endmodule

// File: tb/tb_multdiv_unit.sv
// tb_multdiv_unit: table vectors, corner sequences and random ops against an arithmetic model
module tb_multdiv_unit;
  logic clock, ctrl_reset, ctrl_MULT, ctrl_DIV;
  logic [31:0] data_operandA, data_operandB, data_result;
  logic [4:0] ctrl_tagIn, data_tagOut;
  logic data_exception, data_resultRDY, data_busy;
  int checks = 0, errors = 0;

  multdiv_unit #(.WIDTH(32)) dut (
    .clock(clock), .ctrl_reset(ctrl_reset), .ctrl_MULT(ctrl_MULT), .ctrl_DIV(ctrl_DIV),
    .data_operandA(data_operandA), .data_operandB(data_operandB), .ctrl_tagIn(ctrl_tagIn),
    .data_result(data_result), .data_exception(data_exception), .data_resultRDY(data_resultRDY),
    .data_busy(data_busy), .data_tagOut(data_tagOut)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    bit mul;
    logic [31:0] a, b;
    logic [4:0] tag;
    logic [31:0] res;
    bit exc;
  } vec_t;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
    end
  endtask

  // {exception, result} from plain signed arithmetic
  function automatic logic [32:0] model(input bit mul, input logic [31:0] a, input logic [31:0] b);
    longint p, lo;
    int qt;
    if (mul) begin
      p = longint'($signed(a)) * longint'($signed(b));
      lo = longint'($signed(p[31:0]));
      return {lo != p, p[31:0]};
    end
    if (b == 0) return {1'b1, 32'h0};
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {1'b1, 32'h8000_0000};
    qt = $signed(a) / $signed(b);
    return {1'b0, 32'(qt)};
  endfunction

  // Start at the next edge E, optionally pulse ctrl_DIV at E+inj, and stop at the RDY sample
  task automatic do_op(input bit mul, input logic [31:0] a, input logic [31:0] b, input logic [4:0] tag,
                       input logic [31:0] er, input bit ee, input int inj, input string nm);
    int k, bc;
    logic [31:0] hold_r;
    bit moved;
    hold_r = data_result;
    moved = 0;
    ctrl_MULT = mul;
    ctrl_DIV = !mul;
    data_operandA = a;
    data_operandB = b;
    ctrl_tagIn = tag;
    tick();
    ctrl_MULT = 0;
    ctrl_DIV = 0;
    data_operandA = $urandom;
    data_operandB = $urandom;
    ctrl_tagIn = 5'($urandom);
    k = 0;
    bc = 0;
    while (!data_resultRDY && k < 40) begin
      bc += int'(data_busy);
      if (data_result !== hold_r) moved = 1;
      ctrl_DIV = (k == inj - 1);
      tick();
      k++;
    end
    ctrl_DIV = 0;
    check({nm, " latency"}, 64'(k), mul ? 64'd17 : 64'd33);
    check({nm, " busy cycles"}, 64'(bc), mul ? 64'd17 : 64'd33);
    check({nm, " busy at rdy"}, 64'(data_busy), 64'd0);
    check({nm, " result"}, 64'(data_result), 64'(er));
    check({nm, " exception"}, 64'(data_exception), 64'(ee));
    check({nm, " tag"}, 64'(data_tagOut), 64'(tag));
    check({nm, " result held"}, 64'(moved), 64'd0);
  endtask

  initial begin
    vec_t vt[10];
    logic [32:0] e;
    logic [31:0] a, b;
    bit mul;
    int rdy_seen;
    vt[0] = '{1, 32'd7, 32'hFFFF_FFFD, 5'd5, 32'hFFFF_FFEB, 0};
    vt[1] = '{1, 32'h0001_0000, 32'h0001_0000, 5'd1, 32'h0, 1};
    vt[2] = '{1, 32'h8000_0000, 32'd1, 5'd2, 32'h8000_0000, 0};
    vt[3] = '{0, 32'hFFFF_FF9C, 32'd7, 5'd3, 32'hFFFF_FFF2, 0};
    vt[4] = '{0, 32'd5, 32'd0, 5'd4, 32'h0, 1};
    vt[5] = '{0, 32'h8000_0000, 32'hFFFF_FFFF, 5'd31, 32'h8000_0000, 1};
    vt[6] = '{0, 32'd7, 32'hFFFF_FFFE, 5'd6, 32'hFFFF_FFFD, 0};
    vt[7] = '{1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, 32'h1, 0};
    vt[8] = '{1, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8, 32'h8000_0000, 1};
    vt[9] = '{0, 32'h8000_0000, 32'd1, 5'd9, 32'h8000_0000, 0};
    ctrl_reset = 0;
    ctrl_MULT = 0;
    ctrl_DIV = 0;
    data_operandA = 0;
    data_operandB = 0;
    ctrl_tagIn = 0;
    tick();
    tick();
    check("reset result", 64'(data_result), 64'd0);
    check("reset exception", 64'(data_exception), 64'd0);
    check("reset rdy", 64'(data_resultRDY), 64'd0);
    check("reset busy", 64'(data_busy), 64'd0);
    check("reset tag", 64'(data_tagOut), 64'd0);
    // Reset wins over a simultaneous start
    ctrl_MULT = 1;
    tick();
    check("reset priority busy", 64'(data_busy), 64'd0);
    ctrl_MULT = 0;
    ctrl_reset = 1;
    tick();

    foreach (vt[i]) begin
      do_op(vt[i].mul, vt[i].a, vt[i].b, vt[i].tag, vt[i].res, vt[i].exc, -1, $sformatf("vec%0d", i));
      tick();
      check($sformatf("vec%0d rdy pulse", i), 64'(data_resultRDY), 64'd0);
    end

    do_op(1, 32'd3, 32'd4, 5'd10, 32'd12, 0, 5, "mult ignores div");

    tick();
    ctrl_MULT = 1;
    ctrl_DIV = 1;
    tick();
    ctrl_MULT = 0;
    ctrl_DIV = 0;
    check("both starts busy", 64'(data_busy), 64'd0);
    rdy_seen = 0;
    for (int i = 0; i < 40; i++) begin
      rdy_seen += int'(data_resultRDY);
      tick();
    end
    check("both starts no rdy", 64'(rdy_seen), 64'd0);

    ctrl_DIV = 1;
    data_operandA = 32'd1000;
    data_operandB = 32'd3;
    ctrl_tagIn = 5'd12;
    tick();
    ctrl_DIV = 0;
    for (int i = 1; i < 10; i++) tick();
    ctrl_reset = 0;
    tick();
    ctrl_reset = 1;
    check("abort busy", 64'(data_busy), 64'd0);
    check("abort rdy", 64'(data_resultRDY), 64'd0);
    check("abort result", 64'(data_result), 64'd0);
    check("abort exception", 64'(data_exception), 64'd0);
    check("abort tag", 64'(data_tagOut), 64'd0);
    rdy_seen = 0;
    for (int i = 0; i < 40; i++) begin
      rdy_seen += int'(data_resultRDY) + int'(data_busy);
      tick();
    end
    check("abort stays idle", 64'(rdy_seen), 64'd0);

    // Start issued in the RDY cycle is accepted
    do_op(0, 32'd100, 32'd9, 5'd13, 32'd11, 0, -1, "b2b first");
    do_op(1, 32'hFFFF_FFFE, 32'd21, 5'd14, 32'hFFFF_FFD6, 0, -1, "b2b second");

    for (int n = 0; n < 40; n++) begin
      mul = 1'($urandom);
      a = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'h0;
        1: b = 32'hFFFF_FFFF;
        2: b = 32'($urandom_range(1, 20));
        3: b = -32'($urandom_range(1, 20));
        default: b = $urandom;
      endcase
      e = model(mul, a, b);
      do_op(mul, a, b, 5'($urandom), e[31:0], e[32], -1, $sformatf("rand%0d", n));
      if ($urandom_range(0, 1) == 1) begin
        tick();
        check($sformatf("rand%0d rdy pulse", n), 64'(data_resultRDY), 64'd0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
